// File: rtl/fifo_v4_sram.sv
// rtl/fifo_v4_sram.sv - single-clock FIFO over a synchronous-read RAM with a two-entry head prefetch
module fifo_v4_sram #(
    parameter bit          FALL_THROUGH    = 1'b0,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned ALMOST_FULL_TH  = DEPTH - 1,
    parameter int unsigned ALMOST_EMPTY_TH = 1,
    parameter int unsigned CNT_W           = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i,
    output logic                  empty_o,
    output logic                  almost_empty_o,
    output logic [CNT_W-1:0]      usage_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_TH    = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] AE_TH    = CNT_W'(ALMOST_EMPTY_TH);

    if (ALMOST_FULL_TH > DEPTH) begin : g_bad_af_th
        $error("fifo_v4_sram: ALMOST_FULL_TH must not exceed DEPTH");
    end
    if (ALMOST_EMPTY_TH >= DEPTH) begin : g_bad_ae_th
        $error("fifo_v4_sram: ALMOST_EMPTY_TH must be below DEPTH");
    end

    // Storage and pointers. Oldest entries sit in head, then skid, then the
    // in-flight RAM read, then the RAM itself.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      usage_q, ram_cnt_q;
    logic [DATA_WIDTH-1:0] head_q, skid_q;
    logic                  head_v_q, skid_v_q, rd_pend_q;
    logic                  ovf_q, udf_q;

    logic                  usage_zero, bypass_out;
    logic                  pop_acc, push_acc, pass_thru, byp, ram_wr, rd_en;
    logic                  head_v_n, skid_v_n;
    logic [DATA_WIDTH-1:0] head_n, skid_n;
    logic [CNT_W-1:0]      usage_n, ram_cnt_n;

    assign usage_zero = (usage_q == '0);
    // With fall-through, a push into an empty FIFO is presented immediately.
    assign bypass_out = FALL_THROUGH && usage_zero && push_i;

    assign empty_o        = usage_zero && !bypass_out;
    assign data_o         = bypass_out ? data_i : head_q;
    assign full_o         = (usage_q == CNT_FULL);
    assign almost_full_o  = (usage_q >= AF_TH);
    assign almost_empty_o = (usage_q <= AE_TH);
    assign usage_o        = usage_q;
    assign overflow_o     = ovf_q;
    assign underflow_o    = udf_q;

    // Next-state of the prefetch list: drop popped head, append arriving RAM
    // data, then append a bypassed push if the RAM holds nothing older.
    always_comb begin
        pop_acc   = pop_i && !empty_o && !flush_i;
        push_acc  = push_i && (!full_o || pop_acc) && !flush_i;
        pass_thru = bypass_out && pop_acc;

        head_v_n = head_v_q;
        head_n   = head_q;
        skid_v_n = skid_v_q;
        skid_n   = skid_q;

        if (pop_acc && !pass_thru) begin
            head_v_n = skid_v_q;
            if (skid_v_q) begin
                head_n = skid_q;
            end
            skid_v_n = 1'b0;
        end

        if (rd_pend_q && !flush_i) begin
            if (!head_v_n) begin
                head_v_n = 1'b1;
                head_n   = ram_q;
            end else begin
                skid_v_n = 1'b1;
                skid_n   = ram_q;
            end
        end

        byp = push_acc && !pass_thru && (ram_cnt_q == '0) && !(head_v_n && skid_v_n);
        if (byp) begin
            if (!head_v_n) begin
                head_v_n = 1'b1;
                head_n   = data_i;
            end else begin
                skid_v_n = 1'b1;
                skid_n   = data_i;
            end
        end

        ram_wr = push_acc && !pass_thru && !byp;
        // Prefetch only when the landing slot is guaranteed free next cycle.
        rd_en  = !flush_i && (ram_cnt_q != '0) && !(head_v_n && skid_v_n);

        ram_cnt_n = ram_cnt_q;
        case ({ram_wr, rd_en})
            2'b10:   ram_cnt_n = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_n = ram_cnt_q - 1'b1;
            default: ram_cnt_n = ram_cnt_q;
        endcase

        usage_n = usage_q;
        case ({push_acc, pop_acc})
            2'b10:   usage_n = usage_q + 1'b1;
            2'b01:   usage_n = usage_q - 1'b1;
            default: usage_n = usage_q;
        endcase
    end

    // RAM write port and registered read port; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (ram_wr) begin
            mem[wr_ptr_q] <= data_i;
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr_q];
        end
    end

    // Control state, prefetch registers and sticky error flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usage_q   <= '0;
            ram_cnt_q <= '0;
            head_q    <= '0;
            skid_q    <= '0;
            head_v_q  <= 1'b0;
            skid_v_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            usage_q   <= '0;
            ram_cnt_q <= '0;
            head_v_q  <= 1'b0;
            skid_v_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            if (ram_wr) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            usage_q   <= usage_n;
            ram_cnt_q <= ram_cnt_n;
            head_q    <= head_n;
            skid_q    <= skid_n;
            head_v_q  <= head_v_n;
            skid_v_q  <= skid_v_n;
            rd_pend_q <= rd_en;
            if (push_i && full_o && !pop_acc) begin
                ovf_q <= 1'b1;
            end
            if (pop_i && empty_o) begin
                udf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_v4_sram.sv
// tb/tb_fifo_v4_sram.sv - directed self-checking bench for fifo_v4_sram
module tb_fifo_v4_sram;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    // a: DEPTH=8, b: DEPTH=5, c: DEPTH=16 with thresholds, d: fall-through DEPTH=4
    logic        a_flush = 0, a_push = 0, a_pop = 0;
    logic [31:0] a_din = 0, a_dout;
    logic        a_full, a_af, a_empty, a_ae, a_ovf, a_udf;
    logic [3:0]  a_usage;

    logic        b_flush = 0, b_push = 0, b_pop = 0;
    logic [31:0] b_din = 0, b_dout;
    logic        b_full, b_af, b_empty, b_ae, b_ovf, b_udf;
    logic [2:0]  b_usage;

    logic        c_flush = 0, c_push = 0, c_pop = 0;
    logic [31:0] c_din = 0, c_dout;
    logic        c_full, c_af, c_empty, c_ae, c_ovf, c_udf;
    logic [4:0]  c_usage;

    logic        d_flush = 0, d_push = 0, d_pop = 0;
    logic [31:0] d_din = 0, d_dout;
    logic        d_full, d_af, d_empty, d_ae, d_ovf, d_udf;
    logic [2:0]  d_usage;

    fifo_v4_sram #(.FALL_THROUGH(1'b0), .DATA_WIDTH(32), .DEPTH(8)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .data_i(a_din), .push_i(a_push),
        .full_o(a_full), .almost_full_o(a_af), .data_o(a_dout), .pop_i(a_pop),
        .empty_o(a_empty), .almost_empty_o(a_ae), .usage_o(a_usage),
        .overflow_o(a_ovf), .underflow_o(a_udf));

    fifo_v4_sram #(.FALL_THROUGH(1'b0), .DATA_WIDTH(32), .DEPTH(5)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .data_i(b_din), .push_i(b_push),
        .full_o(b_full), .almost_full_o(b_af), .data_o(b_dout), .pop_i(b_pop),
        .empty_o(b_empty), .almost_empty_o(b_ae), .usage_o(b_usage),
        .overflow_o(b_ovf), .underflow_o(b_udf));

    fifo_v4_sram #(.FALL_THROUGH(1'b0), .DATA_WIDTH(32), .DEPTH(16),
                   .ALMOST_FULL_TH(12), .ALMOST_EMPTY_TH(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .data_i(c_din), .push_i(c_push),
        .full_o(c_full), .almost_full_o(c_af), .data_o(c_dout), .pop_i(c_pop),
        .empty_o(c_empty), .almost_empty_o(c_ae), .usage_o(c_usage),
        .overflow_o(c_ovf), .underflow_o(c_udf));

    fifo_v4_sram #(.FALL_THROUGH(1'b1), .DATA_WIDTH(32), .DEPTH(4)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(d_flush), .data_i(d_din), .push_i(d_push),
        .full_o(d_full), .almost_full_o(d_af), .data_o(d_dout), .pop_i(d_pop),
        .empty_o(d_empty), .almost_empty_o(d_ae), .usage_o(d_usage),
        .overflow_o(d_ovf), .underflow_o(d_udf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n = 1'b0;
        tick();
        got = {a_empty, a_full, a_ae, a_af, a_ovf, a_udf, d_empty, c_ae};
        vectors++;
        if (got !== 8'b1010_0011) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 10100011", got);
        end
        vectors++;
        if (a_usage !== 4'd0 || a_dout !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_usage_data got usage %0d data %h exp 0 0", a_usage, a_dout);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            a_push = 1'b1;
            a_din  = 32'h100 + i;
            tick();
        end
        a_push = 1'b0;
        vectors++;
        if (a_full !== 1'b1 || a_usage !== 4'd8) begin
            miscompares++;
            $display("FAIL fill_full got full %b usage %0d exp 1 8", a_full, a_usage);
        end
        a_pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++;
            if (a_empty !== 1'b0 || a_dout !== 32'h100 + i) begin
                miscompares++;
                $display("FAIL drain_%0d got empty %b data %h exp 0 %h", i, a_empty, a_dout, 32'h100 + i);
            end
            tick();
        end
        a_pop = 1'b0;
        vectors++;
        if (a_empty !== 1'b1 || a_usage !== 4'd0) begin
            miscompares++;
            $display("FAIL drain_empty got empty %b usage %0d exp 1 0", a_empty, a_usage);
        end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < 8; i++) begin
            a_push = 1'b1;
            a_din  = 32'h200 + i;
            tick();
        end
        a_din = 32'hDEAD;
        tick();
        a_push = 1'b0;
        vectors++;
        if (a_ovf !== 1'b1 || a_usage !== 4'd8) begin
            miscompares++;
            $display("FAIL overflow got ovf %b usage %0d exp 1 8", a_ovf, a_usage);
        end
        a_pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++;
            if (a_dout !== 32'h200 + i) begin
                miscompares++;
                $display("FAIL ovf_drain_%0d got %h exp %h", i, a_dout, 32'h200 + i);
            end
            tick();
        end
        vectors++;
        if (a_udf !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_early got %b exp 0", a_udf);
        end
        tick();
        a_pop = 1'b0;
        vectors++;
        if (a_udf !== 1'b1 || a_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow got udf %b ovf %b exp 1 1", a_udf, a_ovf);
        end
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        vectors++;
        if (a_udf !== 1'b0 || a_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_flags got udf %b ovf %b exp 0 0", a_udf, a_ovf);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            b_push = 1'b1;
            b_din  = 32'h10 + i;
            tick();
        end
        b_pop = 1'b1;
        for (int k = 0; k < 20; k++) begin
            b_din = 32'h13 + k;
            #1;
            vectors++;
            if (b_dout !== 32'h10 + k) begin
                miscompares++;
                $display("FAIL wrap_data_%0d got %h exp %h", k, b_dout, 32'h10 + k);
            end
            tick();
            vectors++;
            if (b_usage !== 3'd3) begin
                miscompares++;
                $display("FAIL wrap_usage_%0d got %0d exp 3", k, b_usage);
            end
        end
        b_push = 1'b0;
        b_pop  = 1'b0;
    endtask

    task automatic test_thresholds();
        for (int i = 1; i <= 13; i++) begin
            c_push = 1'b1;
            c_din  = i;
            tick();
            vectors++;
            if (c_af !== (i >= 12)) begin
                miscompares++;
                $display("FAIL almost_full_after_%0d got %b exp %b", i, c_af, (i >= 12));
            end
        end
        c_push = 1'b0;
        c_pop  = 1'b1;
        for (int u = 12; u >= 2; u--) begin
            tick();
            vectors++;
            if (c_ae !== (u <= 2) || c_usage !== u) begin
                miscompares++;
                $display("FAIL almost_empty_at_%0d got ae %b usage %0d exp %b %0d", u, c_ae, c_usage, (u <= 2), u);
            end
        end
        c_pop = 1'b0;
    endtask

    task automatic test_fall_through();
        d_push = 1'b1;
        d_pop  = 1'b1;
        d_din  = 32'hA5;
        #1;
        vectors++;
        if (d_dout !== 32'hA5 || d_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL ft_pass_data got data %h empty %b exp a5 0", d_dout, d_empty);
        end
        tick();
        vectors++;
        if (d_usage !== 3'd0 || d_udf !== 1'b0) begin
            miscompares++;
            $display("FAIL ft_pass_state got usage %0d udf %b exp 0 0", d_usage, d_udf);
        end
        d_pop = 1'b0;
        d_din = 32'h5A;
        #1;
        vectors++;
        if (d_dout !== 32'h5A) begin
            miscompares++;
            $display("FAIL ft_push_data got %h exp 5a", d_dout);
        end
        tick();
        d_push = 1'b0;
        #1;
        vectors++;
        if (d_usage !== 3'd1 || d_dout !== 32'h5A || d_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL ft_push_state got usage %0d data %h empty %b exp 1 5a 0", d_usage, d_dout, d_empty);
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 6; i++) begin
            a_push = 1'b1;
            a_din  = 32'h300 + i;
            tick();
        end
        a_flush = 1'b1;
        a_din   = 32'hBAD;
        tick();
        a_flush = 1'b0;
        a_push  = 1'b0;
        vectors++;
        if (a_usage !== 4'd0 || a_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_state got usage %0d empty %b exp 0 1", a_usage, a_empty);
        end
        for (int i = 0; i < 3; i++) begin
            a_push = 1'b1;
            a_din  = 32'h400 + i;
            tick();
        end
        a_push = 1'b0;
        vectors++;
        if (a_usage !== 4'd3 || a_dout !== 32'h400) begin
            miscompares++;
            $display("FAIL refill got usage %0d data %h exp 3 400", a_usage, a_dout);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (a_usage !== 4'd0 || a_empty !== 1'b1 || a_dout !== 32'd0 || a_ae !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset got usage %0d empty %b data %h ae %b exp 0 1 0 1", a_usage, a_empty, a_dout, a_ae);
        end
        tick();
        rst_n = 1'b1;
        tick();
        a_push = 1'b1;
        a_din  = 32'h77;
        tick();
        a_push = 1'b0;
        vectors++;
        if (a_usage !== 4'd1 || a_dout !== 32'h77 || a_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_push got usage %0d data %h empty %b exp 1 77 0", a_usage, a_dout, a_empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_wrap();
        test_thresholds();
        test_fall_through();
        test_flush_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
